// File: rtl/int_to_fp_arbiter.sv
// Shares one int32 -> bfloat16 converter between NUM_REQ valid/ready requesters, one result register.
// Define INT2FP_ARB_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.

module int_to_bf16 (
    input  logic [31:0] operand,
    input  logic        is_unsigned,
    output logic [15:0] result
);
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  msb;
    logic [30:0] norm;
    logic [7:0]  exp_val;
    logic        round_up;
    logic [14:0] body;

    always_comb begin
        sign = !is_unsigned && operand[31];
        mag  = sign ? (~operand + 32'd1) : operand;
        msb  = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                msb = 5'(i);
            end
        end
        // Leading one is shifted out; norm[30:24] is the kept mantissa, the rest feeds RNE.
        norm     = mag[30:0] << (5'd31 - msb);
        exp_val  = 8'd127 + {3'b000, msb};
        round_up = norm[23] && ((|norm[22:0]) || norm[24]);
        // A mantissa carry ripples into the exponent, which is the correct renormalisation.
        body     = {exp_val, norm[30:24]} + {14'b0, round_up};
        result   = (mag == '0) ? 16'h0000 : {sign, body};
    end
endmodule

module int_to_fp_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_int_i,
    input  logic [NUM_REQ-1:0]    req_unsigned_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [15:0]           resp_fp_o,
    output logic [ID_W-1:0]       resp_id_o
);
    logic            resp_valid_reg;
    logic [15:0]     resp_fp_reg;
    logic [ID_W-1:0] resp_id_reg;
    logic [ID_W-1:0] rr_ptr_reg;

    logic            stage_free;
    logic            grant_en;
    logic            grant_found;
    logic            accept;
    logic [ID_W-1:0] grant_idx;
    logic [31:0]     req_word [NUM_REQ];
    logic [31:0]     conv_operand;
    logic            conv_unsigned;
    logic [15:0]     conv_result;

    assign stage_free = !resp_valid_reg || resp_ready_i;
    assign grant_en   = stage_free && !flush_i && !rst_i;
    assign accept     = grant_en && grant_found;

    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef INT2FP_ARB_RR_EN
            cand = (int'(rr_ptr_reg) + 1 + i) % NUM_REQ;
`else
            cand = i;
`endif
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi]    = req_int_i[32*gi +: 32];
            assign req_ready_o[gi] = grant_en && grant_found && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Single shared converter; only the granted requester's operand reaches it.
    assign conv_operand  = req_word[grant_idx];
    assign conv_unsigned = req_unsigned_i[grant_idx];

    int_to_bf16 u_conv (
        .operand     (conv_operand),
        .is_unsigned (conv_unsigned),
        .result      (conv_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_reg <= 1'b0;
            resp_fp_reg    <= '0;
            resp_id_reg    <= '0;
            rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
        end else if (flush_i) begin
            resp_valid_reg <= 1'b0;
        end else if (accept) begin
            resp_valid_reg <= 1'b1;
            resp_fp_reg    <= conv_result;
            resp_id_reg    <= grant_idx;
            rr_ptr_reg     <= grant_idx;
        end else if (resp_ready_i) begin
            resp_valid_reg <= 1'b0;
        end
    end

    // The pointer must always name a real requester, even when fixed priority ignores it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (int'(rr_ptr_reg) < NUM_REQ);
        end
    end

    assign resp_valid_o = resp_valid_reg;
    assign resp_fp_o    = resp_fp_reg;
    assign resp_id_o    = resp_id_reg;
endmodule

// File: tb/tb_int_to_fp_arbiter.sv
// Randomised and directed bench for int_to_fp_arbiter; a queue scoreboard is fed by a reference model.
// Follows INT2FP_ARB_RR_EN to pick the expected arbitration policy.

module tb_int_to_fp_arbiter;
    localparam int N   = 2;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i;
    logic           flush_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*32-1:0] req_int_i;
    logic [N-1:0]   req_unsigned_i;
    logic           resp_valid_o;
    logic           resp_ready_i;
    logic [15:0]    resp_fp_o;
    logic [IDW-1:0] resp_id_o;

    int_to_fp_arbiter #(.NUM_REQ(N)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_int_i      (req_int_i),
        .req_unsigned_i (req_unsigned_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_fp_o      (resp_fp_o),
        .resp_id_o      (resp_id_o)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    fp;
    } resp_t;

    resp_t          exp_q[$];
    logic [15:0]    held_fp = '0;
    logic [IDW-1:0] held_id = '0;
    int             rr_m    = N - 1;
    int             n_cmp   = 0;
    int             n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference conversion through the exact real value, rounded to nearest-even on the double encoding.
    function automatic logic [15:0] ref_bf16(input logic [31:0] w, input logic uns);
        longint      v;
        real         r;
        logic [63:0] b;
        logic [44:0] rem;
        logic [44:0] half;
        logic [6:0]  m;
        logic [7:0]  e;
        logic [14:0] body;
        v = uns ? longint'({32'h0, w}) : longint'(signed'(w));
        if (v == 0) return 16'h0000;
        r    = real'(v);
        b    = $realtobits(r);
        e    = 8'(int'(b[62:52]) - 1023 + 127);
        m    = b[51:45];
        rem  = b[44:0];
        half = 45'd1 << 44;
        body = {e, m};
        if (rem > half || (rem == half && m[0])) body = body + 15'd1;
        return {b[63], body};
    endfunction

    // Monitor: compares what the DUT presents with the head of the scoreboard.
    always @(negedge clk) begin : monitor
        resp_t e;
        logic  ev;
        ev = (exp_q.size() != 0);
        if (ev) e = exp_q[0];
        else begin
            e.id = held_id;
            e.fp = held_fp;
        end
        chk("resp_valid", 32'(resp_valid_o), 32'(ev));
        chk("resp_fp", 32'(resp_fp_o), 32'(e.fp));
        chk("resp_id", 32'(resp_id_o), 32'(e.id));
        if (ev && resp_ready_i && !flush_i && !rst_i) begin
            void'(exp_q.pop_front());
            $display("resp id=%0d fp=%h", e.id, e.fp);
        end
    end

    // Reference model: decides the grant from the rules and pushes expected results.
    always begin : model
        logic [N-1:0] er;
        int           g;
        resp_t        r;
        @(negedge clk);
        #1;
        er = '0;
        g  = -1;
        if (rst_i) begin
            exp_q.delete();
            held_fp = '0;
            held_id = '0;
            rr_m    = N - 1;
        end else if (flush_i) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
`ifdef INT2FP_ARB_RR_EN
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid_i[(rr_m + k) % N]) g = (rr_m + k) % N;
            end
`else
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid_i[k]) g = k;
            end
`endif
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready_o), 32'(er));
        if (g >= 0) begin
            r.id = IDW'(g);
            r.fp = ref_bf16(req_int_i[32*g +: 32], req_unsigned_i[g]);
            exp_q.push_back(r);
            held_fp = r.fp;
            held_id = r.id;
            rr_m    = g;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] v, input logic u);
        req_int_i[32*k +: 32] = v;
        req_unsigned_i[k]     = u;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'($urandom_range(0, 300));
            2:       return 32'($urandom);
            3:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            4:       return -32'($urandom_range(1, 300));
            default: return 32'($urandom_range(256, 511)) << $urandom_range(0, 22);
        endcase
    endfunction

    initial begin
        logic [N-1:0] acc;
        logic [IDW-1:0] exp_id;
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        resp_ready_i   = 1'b1;
        req_valid_i    = '0;
        req_int_i      = '0;
        req_unsigned_i = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_ready", 32'(req_ready_o), 32'h0);
        step();
        rst_i = 1'b0;

        // Single operation
        set_req(0, 32'd1, 1'b0);
        req_valid_i = 2'b01;
        step();
        req_valid_i = '0;
        @(negedge clk);
        chk("single_valid", 32'(resp_valid_o), 32'h1);
        chk("single_fp", 32'(resp_fp_o), 32'h3F80);
        chk("single_id", 32'(resp_id_o), 32'h0);
        step();

        // Signed and unsigned interpretation of 0xFFFFFFFE
        set_req(1, 32'hFFFF_FFFE, 1'b0);
        req_valid_i = 2'b10;
        step();
        req_valid_i = '0;
        @(negedge clk);
        chk("neg_fp", 32'(resp_fp_o), 32'hC000);
        chk("neg_id", 32'(resp_id_o), 32'h1);
        step();
        set_req(1, 32'hFFFF_FFFE, 1'b1);
        req_valid_i = 2'b10;
        step();
        req_valid_i = '0;
        @(negedge clk);
        chk("uns_sign", 32'(resp_fp_o[15]), 32'h0);
        chk("uns_fp", 32'(resp_fp_o), 32'h4F80);
        step();

        // Conflict: both requesters valid with back-to-back drains
        set_req(0, 32'd3, 1'b0);
        set_req(1, 32'd100, 1'b0);
        req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
`ifdef INT2FP_ARB_RR_EN
            exp_id = IDW'(i % 2);
`else
            exp_id = '0;
`endif
            chk("conflict_id", 32'(resp_id_o), 32'(exp_id));
            chk("conflict_fp", 32'(resp_fp_o), (exp_id == 0) ? 32'h4040 : 32'h42C8);
        end
        step();
        req_valid_i = 2'b10;
        step();
        req_valid_i = '0;
        @(negedge clk);
        chk("release_id", 32'(resp_id_o), 32'h1);
        chk("release_fp", 32'(resp_fp_o), 32'h42C8);
        step();

        // Backpressure with a request waiting
        set_req(0, 32'd1, 1'b0);
        req_valid_i  = 2'b01;
        resp_ready_i = 1'b0;
        step();
        set_req(0, 32'd100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_fp", 32'(resp_fp_o), 32'h3F80);
            chk("bp_ready", 32'(req_ready_o), 32'h0);
            step();
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_accept", 32'(req_ready_o), 32'h1);
        step();
        req_valid_i = '0;
        @(negedge clk);
        chk("bp_next_fp", 32'(resp_fp_o), 32'h42C8);
        step();

        // Flush with a pending result and a waiting request
        resp_ready_i = 1'b0;
        set_req(0, 32'd3, 1'b0);
        req_valid_i = 2'b01;
        step();
        set_req(1, 32'd100, 1'b0);
        req_valid_i  = 2'b10;
        resp_ready_i = 1'b1;
        flush_i      = 1'b1;
        @(negedge clk);
        chk("flush_no_grant", 32'(req_ready_o), 32'h0);
        step();
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;
        @(negedge clk);
        chk("flush_drop", 32'(resp_valid_o), 32'h0);
        step();
        req_valid_i = '0;

        // Reset with a pending result and a waiting request
        set_req(0, 32'd1, 1'b0);
        req_valid_i = 2'b01;
        rst_i       = 1'b1;
        @(negedge clk);
        chk("rst_no_grant", 32'(req_ready_o), 32'h0);
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_drop", 32'(resp_valid_o), 32'h0);
        chk("rst_fp", 32'(resp_fp_o), 32'h0);
        resp_ready_i = 1'b1;
        step();
        req_valid_i = '0;
        step();

        // Zero input in both modes
        for (int u = 0; u < 2; u++) begin
            set_req(0, 32'h0, u[0]);
            req_valid_i = 2'b01;
            step();
            req_valid_i = '0;
            @(negedge clk);
            chk("zero_fp", 32'(resp_fp_o), 32'h0);
            step();
        end

        // Randomised traffic; a requester only changes its request once accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_valid_i & req_ready_o;
            step();
            for (int k = 0; k < N; k++) begin
                if (!req_valid_i[k] || acc[k]) begin
                    req_valid_i[k] = ($urandom_range(0, 2) != 0);
                    set_req(k, rand_word(), 1'($urandom_range(0, 1)));
                end
            end
            resp_ready_i = ($urandom_range(0, 9) < 7);
            flush_i      = ($urandom_range(0, 49) == 0);
            rst_i        = ($urandom_range(0, 149) == 0);
        end

        req_valid_i  = '0;
        resp_ready_i = 1'b1;
        flush_i      = 1'b0;
        rst_i        = 1'b0;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
